// File: rtl/cmd_scheduler_pkg.sv
// Shared definitions for the command scheduler: FSM states, completion codes, field widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cmd_scheduler_pkg;

  localparam int CMD_TYPE_W = 3;
  localparam int CMD_PORT_W = 4;

  typedef logic [CMD_TYPE_W-1:0] cmd_type_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_REPORT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DONE_GOOD    = 2'b00,
    DONE_BAD     = 2'b01,
    DONE_TIMEOUT = 2'b10,
    DONE_ABORT   = 2'b11
  } done_status_t;

  // Index width for an N-entry slot set; a single slot still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmd_scheduler_if.sv
// Transport-layer command handshake: issue strobe with type/port, busy, completion strobes.
// Latency: n/a (wires only).
// Backpressure: cmd_busy holds off new issues; an issue already started is not retracted.
// Ports: master = scheduler (drives cmd_*), slave = transport (drives busy/done).
interface cmd_scheduler_if;
  import cmd_scheduler_pkg::*;

  cmd_type_t             cmd_type;
  logic [CMD_PORT_W-1:0] cmd_port;
  logic                  cmd_val;
  logic                  cmd_busy;
  logic                  cmd_done_good;
  logic                  cmd_done_bad;

  modport master (
    output cmd_type, cmd_port, cmd_val,
    input  cmd_busy, cmd_done_good, cmd_done_bad
  );

  modport slave (
    input  cmd_type, cmd_port, cmd_val,
    output cmd_busy, cmd_done_good, cmd_done_bad
  );

endinterface

// File: rtl/cmd_scheduler_rr_arbiter.sv
// Round-robin pick: first requesting slot strictly after ptr, wrapping; ptr itself is last.
// Latency: combinational.
// Backpressure: none; grant is zero when no request is present.
// Ports: req (N requests), ptr (last winner) -> grant (one-hot), idx (binary index).
module cmd_scheduler_rr_arbiter
  import cmd_scheduler_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    // Walk offsets 1..N so the slot after ptr has highest priority and ptr lowest.
    for (int k = 1; k <= N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/cmd_scheduler.sv
// Sequences posted per-slot commands round-robin onto one transport interface and reports completion.
// Latency: post -> cmd_val 2 cycles after the post edge; completion -> done_val 1 cycle after it.
// Backpressure: cmd_busy blocks granting in IDLE only; posts to an occupied slot are dropped with req_ovf.
// Ports: clk/rst; req_val/req_type/req_pend/req_ovf host slots; abort; tp transport handshake;
//        done_val/done_port/done_status completion report; active = command in ISSUE or WAIT.
module cmd_scheduler
  import cmd_scheduler_pkg::*;
#(
  parameter int                   PORTS     = 4,
  parameter int                   TIMEOUT_W = 20,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT   = 20'hFFFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORTS-1:0]      req_val,
  input  logic [3*PORTS-1:0]    req_type,
  output logic [PORTS-1:0]      req_pend,
  output logic [PORTS-1:0]      req_ovf,
  input  logic                  abort,
  cmd_scheduler_if.master       tp,
  output logic                  done_val,
  output logic [CMD_PORT_W-1:0] done_port,
  output logic [1:0]            done_status,
  output logic                  active
);

  localparam int IW = idx_width(PORTS);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT - 1'b1;

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gnt_idx;
  logic [PORTS-1:0]     gnt_oh;
  logic [TIMEOUT_W-1:0] timer;
  done_status_t         rep_status;
  cmd_type_t            slot_type [PORTS];

  logic [PORTS-1:0] arb_grant;
  logic [IW-1:0]    arb_idx;

  logic [PORTS-1:0] issue_clr;
  logic [PORTS-1:0] occupied;
  logic [PORTS-1:0] accept;
  logic [PORTS-1:0] ovf_n;
  logic [PORTS-1:0] pend_n;

  cmd_scheduler_rr_arbiter #(.N(PORTS), .IW(IW)) u_arb (
    .req   (req_pend),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // The granted slot frees up on the ISSUE edge, so a post landing on that same
  // edge is treated as a post to an empty slot.
  always_comb begin
    issue_clr = (state == ST_ISSUE) ? gnt_oh : '0;
    occupied  = req_pend & ~issue_clr;
    accept    = abort ? '0 : (req_val & ~occupied);
    ovf_n     = abort ? '0 : (req_val & occupied);
    pend_n    = abort ? '0 : (occupied | req_val);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= IW'(PORTS - 1);
      gnt_idx     <= '0;
      gnt_oh      <= '0;
      timer       <= '0;
      rep_status  <= DONE_GOOD;
      req_pend    <= '0;
      req_ovf     <= '0;
      tp.cmd_type <= '0;
      tp.cmd_port <= '0;
      tp.cmd_val  <= 1'b0;
      done_val    <= 1'b0;
      done_port   <= '0;
      done_status <= '0;
      active      <= 1'b0;
      for (int i = 0; i < PORTS; i++) slot_type[i] <= '0;
    end else begin
      tp.cmd_val <= 1'b0;
      done_val   <= 1'b0;
      req_pend   <= pend_n;
      req_ovf    <= ovf_n;
      for (int i = 0; i < PORTS; i++) begin
        if (accept[i]) slot_type[i] <= req_type[3*i +: 3];
      end

      case (state)
        ST_IDLE: begin
          // abort gates the grant because req_pend still shows the pre-abort slots.
          if (!abort && (|req_pend) && !tp.cmd_busy) begin
            gnt_idx <= arb_idx;
            gnt_oh  <= arb_grant;
            ptr     <= arb_idx;
            active  <= 1'b1;
            state   <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (abort) begin
            rep_status <= DONE_ABORT;
            active     <= 1'b0;
            state      <= ST_REPORT;
          end else begin
            tp.cmd_val  <= 1'b1;
            tp.cmd_type <= slot_type[gnt_idx];
            tp.cmd_port <= CMD_PORT_W'(gnt_idx);
            timer       <= '0;
            state       <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (abort) begin
            rep_status <= DONE_ABORT;
            active     <= 1'b0;
            state      <= ST_REPORT;
          end else if (tp.cmd_done_bad) begin
            rep_status <= DONE_BAD;
            active     <= 1'b0;
            state      <= ST_REPORT;
          end else if (tp.cmd_done_good) begin
            rep_status <= DONE_GOOD;
            active     <= 1'b0;
            state      <= ST_REPORT;
          end else if (timer == TMO_LAST) begin
            rep_status <= DONE_TIMEOUT;
            active     <= 1'b0;
            state      <= ST_REPORT;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        ST_REPORT: begin
          done_val    <= 1'b1;
          done_port   <= CMD_PORT_W'(gnt_idx);
          done_status <= rep_status;
          state       <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler: latency, round-robin order, timeout, bad/good priority,
// overflow, abort, reset mid-command and busy backpressure, with hand-computed expectations.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_cmd_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_val;
  logic [11:0] req_type;
  logic [3:0]  req_pend;
  logic [3:0]  req_ovf;
  logic        abort;
  logic        done_val;
  logic [3:0]  done_port;
  logic [1:0]  done_status;
  logic        active;

  int n_total;
  int n_bad;

  cmd_scheduler_if tif ();

  cmd_scheduler #(.PORTS(4), .TIMEOUT_W(8), .TIMEOUT(8'd16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_val     (req_val),
    .req_type    (req_type),
    .req_pend    (req_pend),
    .req_ovf     (req_ovf),
    .abort       (abort),
    .tp          (tif),
    .done_val    (done_val),
    .done_port   (done_port),
    .done_status (done_status),
    .active      (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic post(input int slot, input logic [2:0] t);
    req_val[slot]         = 1'b1;
    req_type[3*slot +: 3] = t;
  endtask

  task automatic complete(input logic good, input logic bad);
    tif.cmd_done_good = good;
    tif.cmd_done_bad  = bad;
    step();
    tif.cmd_done_good = 1'b0;
    tif.cmd_done_bad  = 1'b0;
  endtask

  // Waits (bounded) for cmd_val, checks the issued command and its single-cycle width.
  task automatic expect_issue(input string tag, input int port, input int typ);
    int cnt;
    cnt = 0;
    while (!tif.cmd_val && cnt < 100) begin
      step();
      cnt++;
    end
    check({tag, "_seen"}, tif.cmd_val, 1);
    check({tag, "_port"}, tif.cmd_port, port);
    check({tag, "_type"}, tif.cmd_type, typ);
    step();
    check({tag, "_pulse"}, tif.cmd_val, 0);
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!done_val && cnt < 100) begin
      step();
      cnt++;
    end
  endtask

  task automatic expect_done(input string tag, input int port, input int status);
    int cnt;
    wait_done(cnt);
    check({tag, "_seen"}, done_val, 1);
    check({tag, "_port"}, done_port, port);
    check({tag, "_status"}, done_status, status);
    step();
    check({tag, "_pulse"}, done_val, 0);
  endtask

  task automatic watch_quiet(input int n, output int cv, output int dv);
    cv = 0;
    dv = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (tif.cmd_val) cv++;
      if (done_val) dv++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int cv;
    int dv;
    n_total           = 0;
    n_bad             = 0;
    rst               = 1'b1;
    req_val           = '0;
    req_type          = '0;
    abort             = 1'b0;
    tif.cmd_busy      = 1'b0;
    tif.cmd_done_good = 1'b0;
    tif.cmd_done_bad  = 1'b0;
    step();
    step();
    check("rst_pend", req_pend, 0);
    check("rst_cmd", {tif.cmd_val, tif.cmd_port, tif.cmd_type}, 0);
    check("rst_done", {done_val, done_port, done_status, active, req_ovf}, 0);
    rst = 1'b0;
    step();

    // 1: single post, latency to cmd_val and to done_val.
    post(2, 3'b101);
    step();                                  // edge N
    req_val = '0;
    check("t1_pend", req_pend, 4'b0100);
    check("t1_val_n0", tif.cmd_val, 0);
    step();                                  // edge N+1: grant
    check("t1_val_n1", tif.cmd_val, 0);
    check("t1_active", active, 1);
    step();                                  // edge N+2: issue
    check("t1_val_n2", tif.cmd_val, 1);
    check("t1_port", tif.cmd_port, 2);
    check("t1_type", tif.cmd_type, 5);
    check("t1_pend_clr", req_pend, 0);
    step();
    check("t1_pulse", tif.cmd_val, 0);
    check("t1_type_hold", tif.cmd_type, 5);
    complete(1'b1, 1'b0);                    // edge M
    check("t1_done_m0", done_val, 0);
    step();                                  // edge M+1
    check("t1_done_val", done_val, 1);
    check("t1_done_port", done_port, 2);
    check("t1_done_stat", done_status, 0);
    check("t1_inactive", active, 0);

    // 2: round-robin order, then reposts during slot 3's command.
    do_reset();
    post(0, 3'd1);
    post(1, 3'd2);
    post(3, 3'd3);
    step();
    req_val = '0;
    expect_issue("t2_a", 0, 1);
    complete(1'b1, 1'b0);
    expect_done("t2_a_done", 0, 0);
    expect_issue("t2_b", 1, 2);
    complete(1'b1, 1'b0);
    expect_done("t2_b_done", 1, 0);
    expect_issue("t2_c", 3, 3);
    post(0, 3'd6);
    post(3, 3'd7);
    step();
    req_val = '0;
    check("t2_repend", req_pend, 4'b1001);
    complete(1'b1, 1'b0);
    expect_done("t2_c_done", 3, 0);
    expect_issue("t2_d", 0, 6);
    complete(1'b1, 1'b0);
    expect_done("t2_d_done", 0, 0);
    expect_issue("t2_e", 3, 7);
    complete(1'b1, 1'b0);
    expect_done("t2_e_done", 3, 0);

    // 3: timeout. cmd_val seen after edge E; expect_issue leaves us at E+1, done_val after E+17.
    post(1, 3'd4);
    step();
    req_val = '0;
    expect_issue("t3", 1, 4);
    wait_done(cnt);
    check("t3_tmo_lat", cnt, 16);
    check("t3_port", done_port, 1);
    check("t3_status", done_status, 2'b10);
    step();
    complete(1'b1, 1'b0);
    watch_quiet(5, cv, dv);
    check("t3_late_good", dv, 0);

    // 4: bad beats good; overflow leaves stored type alone.
    post(0, 3'd2);
    step();
    req_val = '0;
    expect_issue("t4_a", 0, 2);
    post(2, 3'd1);
    step();
    req_val = '0;
    post(2, 3'd6);
    step();
    req_val = '0;
    check("t4_ovf", req_ovf, 4'b0100);
    step();
    check("t4_ovf_pulse", req_ovf, 0);
    complete(1'b1, 1'b1);
    expect_done("t4_a_done", 0, 1);
    expect_issue("t4_b", 2, 1);
    complete(1'b1, 1'b0);
    expect_done("t4_b_done", 2, 0);

    // 5: abort in WAIT with others pending; post on the abort cycle is discarded.
    post(1, 3'd3);
    step();
    req_val = '0;
    expect_issue("t5", 1, 3);
    post(0, 3'd1);
    post(3, 3'd2);
    step();
    req_val = '0;
    check("t5_pend", req_pend, 4'b1001);
    abort = 1'b1;
    post(2, 3'd5);
    step();
    abort   = 1'b0;
    req_val = '0;
    check("t5_pend_clr", req_pend, 0);
    check("t5_no_ovf", req_ovf, 0);
    check("t5_inactive", active, 0);
    expect_done("t5_done", 1, 2'b11);
    watch_quiet(10, cv, dv);
    check("t5_no_issue", cv, 0);
    check("t5_pend_end", req_pend, 0);

    // 5b: reset while a command is in WAIT.
    post(2, 3'd5);
    step();
    req_val = '0;
    expect_issue("t5r", 2, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5r_cmd", {tif.cmd_val, tif.cmd_port, tif.cmd_type}, 0);
    check("t5r_out", {done_val, done_port, done_status, active, req_ovf, req_pend}, 0);
    watch_quiet(10, cv, dv);
    check("t5r_no_done", dv, 0);

    // 6: busy holds off issue; busy rising in ISSUE does not retract cmd_val.
    tif.cmd_busy = 1'b1;
    post(0, 3'd3);
    post(1, 3'd4);
    step();
    req_val = '0;
    watch_quiet(8, cv, dv);
    check("t6_busy_hold", cv, 0);
    check("t6_busy_pend", req_pend, 4'b0011);
    tif.cmd_busy = 1'b0;
    step();                                  // edge K: grant
    check("t6_k0", tif.cmd_val, 0);
    step();                                  // edge K+1: issue
    check("t6_k1", tif.cmd_val, 1);
    check("t6_port", tif.cmd_port, 0);
    step();
    complete(1'b1, 1'b0);
    expect_done("t6_a_done", 0, 0);          // returns just after IDLE grants slot 1
    tif.cmd_busy = 1'b1;
    step();
    check("t6_no_retract", tif.cmd_val, 1);
    check("t6_b_port", tif.cmd_port, 1);
    tif.cmd_busy = 1'b0;
    step();
    complete(1'b0, 1'b0);
    complete(1'b1, 1'b0);
    expect_done("t6_b_done", 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
